// File: rtl/nvme_sq_buffer_pkg.sv
// Shared constants and types for the NVMe submission-queue buffer.
// Covers the queue geometry, AXI response codes, burst encodings and the entry type.
package nvme_pkg;
    localparam int SQ_DEPTH       = 16;
    localparam int SQ_ENTRY_BYTES = 64;
    localparam int SQ_IDX_W       = $clog2(SQ_DEPTH);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    typedef logic [SQ_ENTRY_BYTES*8-1:0] sq_entry_t;
endpackage

// File: rtl/nvme_sq_buffer_if.sv
// Full AXI4 bus bundle, used for the 512-bit command port and the 128-bit fetch port.
interface nvme_sq_buffer_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/nvme_sq_buffer_rd_engine.sv
// Read-burst engine for the fetch port: walks 16-byte lanes of the queue and
// presents each beat from an output register that holds steady under backpressure.
module nvme_sq_rd_engine
    import nvme_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [9:0]            araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [SQ_IDX_W-1:0]   rd_idx,
    input  sq_entry_t             rd_entry
);
    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    state_e                state_reg, state_next;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [9:0]            addr_reg;
    logic [7:0]            len_reg;
    logic [7:0]            beat_reg;
    logic                  size_ok_reg;
    logic                  fixed_reg;
    logic                  rvalid_reg;
    logic                  rlast_reg;
    logic [1:0]            rresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    logic                  load;
    logic [9:0]            ld_addr;
    logic [7:0]            ld_beat;
    logic [7:0]            ld_len;
    logic                  ld_size_ok;
    logic                  r_hs;
    logic [3:0][DATA_WIDTH-1:0] lanes;

    assign lanes   = rd_entry;
    assign arready = (state_reg == ST_IDLE);
    assign r_hs    = rvalid_reg & rready;
    assign rd_idx  = ld_addr[9:6];

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        ld_addr    = addr_reg;
        ld_beat    = beat_reg;
        ld_len     = len_reg;
        ld_size_ok = size_ok_reg;
        case (state_reg)
            ST_IDLE: begin
                if (arvalid) begin
                    load       = 1'b1;
                    ld_addr    = araddr;
                    ld_beat    = 8'd0;
                    ld_len     = arlen;
                    ld_size_ok = (arsize == 3'd4);
                    state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (r_hs) begin
                    if (beat_reg == len_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        // WRAP deliberately steps like INCR; the 10-bit adder wraps at 1 KiB.
                        load    = 1'b1;
                        ld_addr = fixed_reg ? addr_reg : addr_reg + 10'd16;
                        ld_beat = beat_reg + 8'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= ST_IDLE;
            id_reg      <= '0;
            addr_reg    <= '0;
            len_reg     <= '0;
            beat_reg    <= '0;
            size_ok_reg <= 1'b0;
            fixed_reg   <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rresp_reg   <= OKAY;
            rdata_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && arvalid) begin
                id_reg      <= arid;
                len_reg     <= arlen;
                size_ok_reg <= ld_size_ok;
                fixed_reg   <= (arburst == FIXED);
            end
            if (load) begin
                addr_reg   <= ld_addr;
                beat_reg   <= ld_beat;
                rvalid_reg <= 1'b1;
                rlast_reg  <= (ld_beat == ld_len);
                rresp_reg  <= ld_size_ok ? OKAY : SLVERR;
                rdata_reg  <= ld_size_ok ? lanes[ld_addr[5:4]] : '0;
            end else if (r_hs) begin
                rvalid_reg <= 1'b0;
                rlast_reg  <= 1'b0;
            end
        end
    end

    assign rid    = id_reg;
    assign rdata  = rdata_reg;
    assign rresp  = rresp_reg;
    assign rlast  = rlast_reg;
    assign rvalid = rvalid_reg;
endmodule

// File: rtl/nvme_sq_buffer.sv
// 16 x 64 B NVMe submission queue: written whole-entry by the command driver on sq,
// fetched by the SSD over the 128-bit ns port, which refuses all writes.
module nvme_sq_buffer
    import nvme_pkg::*;
#(
    parameter int SQ_ADDR_WIDTH = 10,
    parameter int SQ_DATA_WIDTH = 512,
    parameter int NS_ID_WIDTH   = 4,
    parameter int NS_ADDR_WIDTH = 32,
    parameter int NS_DATA_WIDTH = 128
) (
    input  logic             clk,
    input  logic             rstn,
    nvme_sq_buffer_if.slave  sq,
    nvme_sq_buffer_if.slave  ns
);
    logic [SQ_DEPTH-1:0][SQ_DATA_WIDTH-1:0] entries;

    // ---------------- sq write path ----------------
    logic                      aw_held_reg;
    logic [SQ_IDX_W-1:0]       aw_idx_reg;
    logic [7:0]                aw_len_reg;
    logic                      w_held_reg;
    sq_entry_t                 w_data_reg;
    logic [SQ_ENTRY_BYTES-1:0] w_strb_reg;
    logic                      w_last_reg;
    logic                      sq_bvalid_reg;
    logic [1:0]                sq_bresp_reg;

    logic                      sq_aw_hs, sq_w_hs;
    logic                      aw_v, w_v;
    logic [SQ_IDX_W-1:0]       aw_idx;
    logic [7:0]                aw_len;
    sq_entry_t                 w_data;
    logic [SQ_ENTRY_BYTES-1:0] w_strb;
    logic                      w_last;
    logic                      sq_fire, sq_done, sq_commit;

    assign sq.awready = ~aw_held_reg & ~sq_bvalid_reg;
    assign sq.wready  = ~w_held_reg & ~sq_bvalid_reg;
    assign sq_aw_hs   = sq.awvalid & sq.awready;
    assign sq_w_hs    = sq.wvalid & sq.wready;

    // Each half is either already held or arriving this edge; the pair fires together.
    assign aw_v   = aw_held_reg | sq_aw_hs;
    assign aw_idx = aw_held_reg ? aw_idx_reg : sq.awaddr[9:6];
    assign aw_len = aw_held_reg ? aw_len_reg : sq.awlen;
    assign w_v    = w_held_reg | sq_w_hs;
    assign w_data = w_held_reg ? w_data_reg : sq.wdata;
    assign w_strb = w_held_reg ? w_strb_reg : sq.wstrb;
    assign w_last = w_held_reg ? w_last_reg : sq.wlast;

    assign sq_fire   = aw_v & w_v;
    assign sq_commit = sq_fire & (aw_len == 8'd0);
    assign sq_done   = sq_fire & ((aw_len == 8'd0) | w_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held_reg   <= 1'b0;
            aw_idx_reg    <= '0;
            aw_len_reg    <= '0;
            w_held_reg    <= 1'b0;
            w_data_reg    <= '0;
            w_strb_reg    <= '0;
            w_last_reg    <= 1'b0;
            sq_bvalid_reg <= 1'b0;
            sq_bresp_reg  <= OKAY;
        end else begin
            if (sq_aw_hs) begin
                aw_idx_reg <= sq.awaddr[9:6];
                aw_len_reg <= sq.awlen;
            end
            if (sq_w_hs) begin
                w_data_reg <= sq.wdata;
                w_strb_reg <= sq.wstrb;
                w_last_reg <= sq.wlast;
            end
            // A multi-beat burst keeps its address half until wlast drains.
            aw_held_reg <= aw_v & ~sq_done;
            w_held_reg  <= w_v & ~sq_fire;
            if (sq_done) begin
                sq_bvalid_reg <= 1'b1;
                sq_bresp_reg  <= sq_commit ? OKAY : SLVERR;
            end else if (sq.bready) begin
                sq_bvalid_reg <= 1'b0;
                sq_bresp_reg  <= OKAY;
            end
        end
    end

    for (genvar gi = 0; gi < SQ_DEPTH; gi++) begin : g_entry
        sq_entry_t entry_reg;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                entry_reg <= '0;
            end else if (sq_commit && aw_idx == SQ_IDX_W'(gi)) begin
                for (int b = 0; b < SQ_ENTRY_BYTES; b++) begin
                    if (w_strb[b]) entry_reg[b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
        assign entries[gi] = entry_reg;
    end

    assign sq.bvalid  = sq_bvalid_reg;
    assign sq.bresp   = sq_bresp_reg;
    assign sq.bid     = '0;
    assign sq.arready = 1'b0;
    assign sq.rvalid  = 1'b0;
    assign sq.rdata   = '0;
    assign sq.rresp   = OKAY;
    assign sq.rlast   = 1'b0;
    assign sq.rid     = '0;

    // ---------------- ns write refusal ----------------
    logic                   ns_wr_busy_reg;
    logic                   ns_bvalid_reg;
    logic [NS_ID_WIDTH-1:0] ns_bid_reg;

    assign ns.awready = ~ns_wr_busy_reg & ~ns_bvalid_reg;
    assign ns.wready  = ns_wr_busy_reg;
    assign ns.bvalid  = ns_bvalid_reg;
    assign ns.bresp   = ns_bvalid_reg ? SLVERR : OKAY;
    assign ns.bid     = ns_bid_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ns_wr_busy_reg <= 1'b0;
            ns_bvalid_reg  <= 1'b0;
            ns_bid_reg     <= '0;
        end else begin
            if (ns.awvalid && ns.awready) begin
                ns_wr_busy_reg <= 1'b1;
                ns_bid_reg     <= ns.awid;
            end
            if (ns.wvalid && ns.wready && ns.wlast) begin
                ns_wr_busy_reg <= 1'b0;
                ns_bvalid_reg  <= 1'b1;
            end else if (ns_bvalid_reg && ns.bready) begin
                ns_bvalid_reg <= 1'b0;
            end
        end
    end

    // ---------------- ns read engine ----------------
    logic [SQ_IDX_W-1:0] rd_idx;

    nvme_sq_rd_engine #(
        .ID_WIDTH   (NS_ID_WIDTH),
        .DATA_WIDTH (NS_DATA_WIDTH)
    ) u_rd_engine (
        .clk      (clk),
        .rstn     (rstn),
        .arid     (ns.arid),
        .araddr   (ns.araddr[9:0]),
        .arlen    (ns.arlen),
        .arsize   (ns.arsize),
        .arburst  (ns.arburst),
        .arvalid  (ns.arvalid),
        .arready  (ns.arready),
        .rid      (ns.rid),
        .rdata    (ns.rdata),
        .rresp    (ns.rresp),
        .rlast    (ns.rlast),
        .rvalid   (ns.rvalid),
        .rready   (ns.rready),
        .rd_idx   (rd_idx),
        .rd_entry (entries[rd_idx])
    );

    // Only the low 10 address bits are decoded; the remaining inputs carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{sq.awid, sq.awaddr, sq.awsize, sq.awburst, sq.arid, sq.araddr,
                         sq.arlen, sq.arsize, sq.arburst, sq.arvalid, sq.rready,
                         ns.awaddr, ns.awlen, ns.awsize, ns.awburst, ns.wdata, ns.wstrb,
                         ns.araddr};
endmodule
